// File: rtl/dm_responder.sv
// dm_responder: slave-side data-memory responder for the processor DM port.
// It accepts one load or store at a time. It waits a fixed LATENCY in clock
// edges and then pulses done for one cycle.
// Optional feature: define DM_RANGE_CHECK_EN to add the registered err output.
// With the macro defined, an access to an address >= DEPTH is flagged, a store
// to it is dropped and a load from it returns 32'hDEADBEEF.
module dm_responder #(
   parameter int    ADDR_W    = 7,
   parameter int    DATA_W    = 32,
   parameter int    DEPTH     = 128,
   parameter int    LATENCY   = 2,
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic              wea,
   input  logic [ADDR_W-1:0] addra,
   input  logic [DATA_W-1:0] dina,
   output logic [DATA_W-1:0] douta,
   output logic              done
`ifdef DM_RANGE_CHECK_EN
   ,
   output logic              err
`endif
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;

   // Request captured at accept; later input changes are ignored
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [DATA_W-1:0] din_q;

   logic [DATA_W-1:0] mem [DEPTH];

   // Access being committed on this edge (the edge that enters RESP)
   logic              commit;
   logic              c_we;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_din;
   logic [IDX_W-1:0]  c_idx;
   logic              mem_we;

   // Select the committing access; with LATENCY==1 it commits on the accept edge itself
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
      commit = 1'b0;
      c_we   = we_q;
      c_addr = addr_q;
      c_din  = din_q;
      if (state == WAIT && cnt == CNT_W'(1)) begin
         commit = 1'b1;
      end
      if (LATENCY == 1 && state == IDLE && ena) begin
         commit = 1'b1;
         c_we   = wea;
         c_addr = addra;
         c_din  = dina;
      end
   end

   // Word index, taken modulo the array size
   assign c_idx = IDX_W'({{(32-ADDR_W){1'b0}}, c_addr} % 32'(DEPTH));

`ifdef DM_RANGE_CHECK_EN
   logic c_oor;
   assign c_oor  = ({{(32-ADDR_W){1'b0}}, c_addr} >= 32'(DEPTH));
   assign mem_we = commit && c_we && !c_oor;
`else
   assign mem_we = commit && c_we;
`endif

   // Storage array write port
   // NOTE: the array has no reset. Clearing it would prevent RAM inference, and reset must not destroy its contents.
   always @(posedge clk) begin
      if (mem_we) begin
         mem[c_idx] <= c_din;
      end
   end

   // Access FSM with registered done/douta (and err)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         done   <= 1'b0;
         douta  <= '0;
         addr_q <= '0;
         we_q   <= 1'b0;
         din_q  <= '0;
`ifdef DM_RANGE_CHECK_EN
         err    <= 1'b0;
`endif
      end else begin
         // NOTE: state registers use non-blocking assignments, so every read in this block sees pre-edge values.
         done <= commit;
`ifdef DM_RANGE_CHECK_EN
         err  <= commit && c_oor;
         if (commit && !c_we) begin
            douta <= c_oor ? DATA_W'(32'hDEAD_BEEF) : mem[c_idx];
         end
`else
         if (commit && !c_we) begin
            douta <= mem[c_idx];
         end
`endif
         case (state)
            IDLE: begin
               if (ena) begin
                  addr_q <= addra;
                  we_q   <= wea;
                  din_q  <= dina;
                  cnt    <= CNT_W'(LATENCY - 1);
                  state  <= (LATENCY == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed bench for dm_responder (LATENCY=2).
// A transaction-level model predicts done/douta/err from request timing.
// One monitor compares the DUT against that model on every falling edge.
// Literal expectations pin the model at the key points.
module tb_dm_responder;

   localparam int AW  = 7;
   localparam int DW  = 32;
   localparam int LAT = 2;
`ifdef DM_RANGE_CHECK_EN
   localparam int DEP = 64;
`else
   localparam int DEP = 128;
`endif

   logic          clk   = 1'b0;
   logic          rst   = 1'b0;
   logic          ena   = 1'b0;
   logic          wea   = 1'b0;
   logic [AW-1:0] addra = '0;
   logic [DW-1:0] dina  = '0;
   logic [DW-1:0] douta;
   logic          done;
`ifdef DM_RANGE_CHECK_EN
   logic          err;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int done_cnt    = 0;
   bit mon_on      = 1'b0;

   always #5 clk = ~clk;

   dm_responder #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .DEPTH  (DEP),
      .LATENCY(LAT)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .wea  (wea),
      .addra(addra),
      .dina (dina),
      .douta(douta),
      .done (done)
`ifdef DM_RANGE_CHECK_EN
      ,
      .err  (err)
`endif
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // An access accepted at edge number E completes at edge E+LAT-1.
   // The responder is free again from edge E+LAT+1 on.
   logic [DW-1:0] m_mem   [DEP];
   bit            m_known [DEP];
   logic [DW-1:0] m_douta = '0;
   bit            m_douta_known = 1'b1;
   logic          m_done = 1'b0;
   logic          m_err  = 1'b0;
   longint        cyc = 0, free_at = 0, commit_at = 0;
   bit            pend = 1'b0;
   bit            p_we;
   int            p_addr;
   logic [DW-1:0] p_din;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_done        = 1'b0;
         m_err         = 1'b0;
         m_douta       = '0;
         m_douta_known = 1'b1;
         pend          = 1'b0;
         free_at       = 0;
      end else begin
         cyc++;
         m_done = 1'b0;
         m_err  = 1'b0;
         if (!pend && cyc >= free_at && ena === 1'b1) begin
            pend      = 1'b1;
            p_we      = wea;
            p_addr    = int'(addra);
            p_din     = dina;
            commit_at = cyc + LAT - 1;
            free_at   = cyc + LAT + 1;
         end
         if (pend && cyc == commit_at) begin
            pend   = 1'b0;
            m_done = 1'b1;
            if (p_addr >= DEP) begin
               m_err = 1'b1;
               if (!p_we) begin
                  m_douta       = 32'hDEAD_BEEF;
                  m_douta_known = 1'b1;
               end
            end else if (p_we) begin
               m_mem[p_addr]   = p_din;
               m_known[p_addr] = 1'b1;
            end else begin
               m_douta       = m_mem[p_addr];
               m_douta_known = m_known[p_addr];
            end
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (mon_on) begin
         check("done", {31'b0, done}, {31'b0, m_done});
         if (m_douta_known) check("douta", douta, m_douta);
`ifdef DM_RANGE_CHECK_EN
         check("err", {31'b0, err}, {31'b0, m_err});
`endif
         if (done === 1'b1) done_cnt++;
      end
   end

   // One access. lat counts edges from the accept edge to the done edge, inclusive.
   task automatic req(input bit we, input int addr, input logic [DW-1:0] d,
                      output int lat, output logic [DW-1:0] d_out, output logic e_out);
      @(posedge clk); #1;
      ena = 1'b1; wea = we; addra = AW'(addr); dina = d;
      @(posedge clk); #1;
      ena = 1'b0;
      lat = -1; d_out = 'x; e_out = 1'bx;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            lat   = i + 1;
            d_out = douta;
`ifdef DM_RANGE_CHECK_EN
            e_out = err;
`else
            e_out = 1'b0;
`endif
            break;
         end
      end
      check("req_latency", lat, LAT);
      @(posedge clk); #1;
      check("done_one_cycle", {31'b0, done}, 32'd0);
   endtask

   int            lat, base, t_first, t_second;
   logic [DW-1:0] d_out, d_first;
   logic          e_out;

   initial begin
      // 1: reset, then idle
      #1 rst = 1'b1;
      #1 mon_on = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #2;
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_douta", douta, 32'd0);
      repeat (5) @(posedge clk);
      #2 check("idle_no_done", done_cnt, 0);

      // 2: store 5
      req(1'b1, 5, 32'h1234_5678, lat, d_out, e_out);
      check("store_douta_unchanged", d_out, 32'd0);
      check("store_one_pulse", done_cnt, 1);

      // 3: load 5, data held afterwards
      req(1'b0, 5, 32'h0, lat, d_out, e_out);
      check("load5_data", d_out, 32'h1234_5678);
      repeat (3) @(posedge clk);
      #1 check("load5_held", douta, 32'h1234_5678);

      // 4: ena held high with new addr/wea during WAIT
      @(posedge clk); #1;
      ena = 1'b1; wea = 1'b0; addra = AW'(5);
      @(posedge clk); #1;
      addra = AW'(9); wea = 1'b1; dina = 32'hCAFE_0009;
      t_first = -1; t_second = -1; d_first = '0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            if (t_first < 0) begin
               t_first = i;
               d_first = douta;
            end else if (t_second < 0) begin
               t_second = i;
            end
         end
         if (i == 3) ena = 1'b0;
      end
      check("held_first_edge", t_first, 1);
      check("held_first_is_load5", d_first, 32'h1234_5678);
      check("held_second_edge", t_second, 4);
      req(1'b0, 9, 32'h0, lat, d_out, e_out);
      check("load9_data", d_out, 32'hCAFE_0009);

      // 5: reset during WAIT aborts a store
      req(1'b1, 7, 32'h0BAD_F00D, lat, d_out, e_out);
      @(posedge clk); #1;
      ena = 1'b1; wea = 1'b1; addra = AW'(7); dina = 32'hAAAA_AAAA;
      @(posedge clk); #1;
      ena = 1'b0;
      base = done_cnt;
      #2 rst = 1'b1;
      #3 rst = 1'b0;
      repeat (5) @(posedge clk);
      #2 check("abort_no_done", done_cnt, base);
      req(1'b0, 7, 32'h0, lat, d_out, e_out);
      check("load7_old_value", d_out, 32'h0BAD_F00D);

`ifdef DM_RANGE_CHECK_EN
      // 6: out-of-range accesses with DEPTH=64 (addr 100 would alias to 36)
      req(1'b1, 36, 32'h3636_3636, lat, d_out, e_out);
      check("st36_err", {31'b0, e_out}, 32'd0);
      req(1'b0, 100, 32'h0, lat, d_out, e_out);
      check("ld100_err", {31'b0, e_out}, 32'd1);
      check("ld100_data", d_out, 32'hDEAD_BEEF);
      req(1'b1, 100, 32'h1111_1111, lat, d_out, e_out);
      check("st100_err", {31'b0, e_out}, 32'd1);
      req(1'b0, 36, 32'h0, lat, d_out, e_out);
      check("ld36_untouched", d_out, 32'h3636_3636);
      check("ld36_err", {31'b0, e_out}, 32'd0);
`endif

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
      $fatal(1, "timeout");
   end

endmodule
